// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA grid renderer family.
// Default timing is standard 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_CELL_LOG2 = 5;
  localparam int DEF_GRID_COLS = 20;
  localparam int DEF_GRID_ROWS = 15;
  localparam int DEF_EDGE_W    = 1;

  localparam int COLOR_W = 3;

  localparam logic [3*COLOR_W-1:0] BLACK = '0;
  localparam logic [3*COLOR_W-1:0] WHITE = '1;

  // One pixel colour, packed as {R,G,B} so it matches the flat colour ports.
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Map a "sync asserted" flag onto the pin level for the chosen polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_grid_renderer_if.sv
// Tile-colour memory port of the grid renderer.
// Protocol: there is no valid/ready. The renderer (master) drives a registered
// cell address every pixel clock; the memory (slave) must present the colour
// of that cell on i_Cell_Color in time for the next rising edge, which is
// where the renderer captures it. The address therefore leads the pixel that
// uses it by exactly one cycle, and the read can never be stalled.
interface vga_grid_renderer_if #(
  parameter int COL_W   = 5,
  parameter int ROW_W   = 4,
  parameter int COLOR_W = 3
);

  logic [COL_W-1:0]     o_Cell_Col;
  logic [ROW_W-1:0]     o_Cell_Row;
  logic [3*COLOR_W-1:0] i_Cell_Color;

  modport master (
    output o_Cell_Col,
    output o_Cell_Row,
    input  i_Cell_Color
  );

  modport slave (
    input  o_Cell_Col,
    input  o_Cell_Row,
    output i_Cell_Color
  );

endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster counters with raw (unregistered, active-high)
// sync, active-area and frame-start flags decoded from the counter state.
// Kept separate so sprite layers can share the same raster.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  output logic [HW-1:0] o_H,
  output logic [VW-1:0] o_V,
  output logic          o_HSync_Raw,
  output logic          o_VSync_Raw,
  output logic          o_Active,
  output logic          o_Frame_Start
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [HW-1:0] H_DISP_C = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_START = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);
  localparam logic [VW-1:0] V_DISP_C = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_START = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Advance the pixel counter; bump the line counter when a line wraps.
  always_comb begin
    h_d = h_q + H_ONE;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : (v_q + V_ONE);
    end
  end

  // Raster position register; reset restarts a full frame at (0,0).
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign o_H           = h_q;
  assign o_V           = v_q;
  assign o_HSync_Raw   = (h_q >= HS_START) && (h_q < HS_END);
  assign o_VSync_Raw   = (v_q >= VS_START) && (v_q < VS_END);
  assign o_Active      = (h_q < H_DISP_C) && (v_q < V_DISP_C);
  assign o_Frame_Start = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_grid_renderer.sv
// Grid renderer: raster timing, tile-memory addressing and pixel composition
// (tile colour, cell borders, cursor highlight). Every output sits exactly two
// registers behind the raster counters so colour and sync stay aligned.
module vga_grid_renderer
  import vga_pkg::*;
#(
  parameter int   H_DISPLAY = DEF_H_DISPLAY,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_DISPLAY = DEF_V_DISPLAY,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   CELL_LOG2 = DEF_CELL_LOG2,
  parameter int   GRID_COLS = DEF_GRID_COLS,
  parameter int   GRID_ROWS = DEF_GRID_ROWS,
  parameter int   EDGE_W    = DEF_EDGE_W,
  parameter int   COLOR_W   = vga_pkg::COLOR_W,
  localparam int  COL_W     = $clog2(GRID_COLS),
  localparam int  ROW_W     = $clog2(GRID_ROWS),
  localparam int  CLR_W     = 3 * COLOR_W
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Edge_En,
  input  logic [CLR_W-1:0]   i_Edge_Color,
  input  logic [COL_W-1:0]   i_Cursor_Col,
  input  logic [ROW_W-1:0]   i_Cursor_Row,
  input  logic [CLR_W-1:0]   i_Cursor_Color,
  vga_grid_renderer_if.master tile,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic [COLOR_W-1:0] o_Red,
  output logic [COLOR_W-1:0] o_Green,
  output logic [COLOR_W-1:0] o_Blue,
  output logic               o_Frame_Start,
  output logic               o_Vblank
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HCW     = HW - CELL_LOG2;
  localparam int VCW     = VW - CELL_LOG2;

  localparam logic [HCW-1:0]       COL_MAX  = HCW'(GRID_COLS - 1);
  localparam logic [VCW-1:0]       ROW_MAX  = VCW'(GRID_ROWS - 1);
  localparam logic [COL_W:0]       CUR_COLS = (COL_W + 1)'(GRID_COLS);
  localparam logic [ROW_W:0]       CUR_ROWS = (ROW_W + 1)'(GRID_ROWS);
  localparam logic [CELL_LOG2-1:0] EDGE_LO  = CELL_LOG2'(EDGE_W);
  localparam logic [CELL_LOG2-1:0] EDGE_HI  = CELL_LOG2'((1 << CELL_LOG2) - EDGE_W);
  localparam logic [VW-1:0]        V_DISP_C = VW'(V_DISPLAY);

  // Stage 0: raster counters.
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hs_raw, vs_raw, active, fs_raw;

  vga_timing #(
    .H_DISPLAY (H_DISPLAY),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_DISPLAY (V_DISPLAY),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .o_H           (h),
    .o_V           (v),
    .o_HSync_Raw   (hs_raw),
    .o_VSync_Raw   (vs_raw),
    .o_Active      (active),
    .o_Frame_Start (fs_raw)
  );

  // Cell index is the counter above the offset bits; offset is the low bits.
  logic [HCW-1:0]       h_cell;
  logic [VCW-1:0]       v_cell;
  logic [CELL_LOG2-1:0] h_off, v_off;

  assign h_cell = h[HW-1:CELL_LOG2];
  assign v_cell = v[VW-1:CELL_LOG2];
  assign h_off  = h[CELL_LOG2-1:0];
  assign v_off  = v[CELL_LOG2-1:0];

  // Stage 1 signals.
  logic [COL_W-1:0] cell_col_d, cell_col_q;
  logic [ROW_W-1:0] cell_row_d, cell_row_q;
  logic             in_grid_d, in_grid_q;
  logic             edge_d, edge_q;
  logic             hit_d, hit_q;
  logic             cursor_valid;
  logic             vblank_d, vblank_s1_q;
  logic             active_s1_q, hs_s1_q, vs_s1_q, fs_s1_q;

  // Stage 1 decode: clamped cell address plus per-pixel classification flags.
  always_comb begin
    cell_col_d   = (h_cell > COL_MAX) ? COL_W'(COL_MAX) : COL_W'(h_cell);
    cell_row_d   = (v_cell > ROW_MAX) ? ROW_W'(ROW_MAX) : ROW_W'(v_cell);
    in_grid_d    = (h_cell <= COL_MAX) && (v_cell <= ROW_MAX);
    edge_d       = (h_off < EDGE_LO) || (h_off >= EDGE_HI) ||
                   (v_off < EDGE_LO) || (v_off >= EDGE_HI);
    // A cursor outside the grid can never match a real cell.
    cursor_valid = ({1'b0, i_Cursor_Col} < CUR_COLS) && ({1'b0, i_Cursor_Row} < CUR_ROWS);
    hit_d        = cursor_valid && (i_Cursor_Col == cell_col_d) && (i_Cursor_Row == cell_row_d);
    vblank_d     = (v >= V_DISP_C);
  end

  // Stage 1 registers: tile-memory address and flags for the pixel mux.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cell_col_q  <= '0;
      cell_row_q  <= '0;
      in_grid_q   <= 1'b0;
      edge_q      <= 1'b0;
      hit_q       <= 1'b0;
      active_s1_q <= 1'b0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      fs_s1_q     <= 1'b0;
      vblank_s1_q <= 1'b0;
    end else begin
      cell_col_q  <= cell_col_d;
      cell_row_q  <= cell_row_d;
      in_grid_q   <= in_grid_d;
      edge_q      <= edge_d;
      hit_q       <= hit_d;
      active_s1_q <= active;
      hs_s1_q     <= hs_raw;
      vs_s1_q     <= vs_raw;
      fs_s1_q     <= fs_raw;
      vblank_s1_q <= vblank_d;
    end
  end

  assign tile.o_Cell_Col = cell_col_q;
  assign tile.o_Cell_Row = cell_row_q;

  // Stage 2 signals.
  logic [CLR_W-1:0] pix_d, pix_q;
  logic             hsync_q, vsync_q, vblank_q, fs_q;

  // Pixel priority: blank outside the grid, then borders, then tile colour.
  always_comb begin
    pix_d = '0;
    if (active_s1_q && in_grid_q) begin
      if (edge_q && i_Edge_En) begin
        pix_d = hit_q ? i_Cursor_Color : i_Edge_Color;
      end else begin
        pix_d = tile.i_Cell_Color;
      end
    end
  end

  // Stage 2 registers: everything that reaches the pins.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pix_q    <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      vblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      pix_q    <= pix_d;
      hsync_q  <= sync_level(hs_s1_q, SYNC_POL);
      vsync_q  <= sync_level(vs_s1_q, SYNC_POL);
      vblank_q <= vblank_s1_q;
      fs_q     <= fs_s1_q;
    end
  end

  assign o_Red         = pix_q[3*COLOR_W-1:2*COLOR_W];
  assign o_Green       = pix_q[2*COLOR_W-1:COLOR_W];
  assign o_Blue        = pix_q[COLOR_W-1:0];
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Vblank      = vblank_q;
  assign o_Frame_Start = fs_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Randomised bench for vga_grid_renderer on a shrunken raster so several
// frames fit in a short run. Expected outputs come from a pixel-coordinate
// model (division/modulo of a linear pixel index) held in latency queues.
module tb_vga_grid_renderer;
  import vga_pkg::*;

  // Small raster: 56 x 31 clocks, 3x3 grid of 8-pixel cells inside 40x24.
  localparam int HD = 40, HF = 4, HS = 6, HB = 6;
  localparam int VD = 24, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CL = 3, CELL = 1 << CL;
  localparam int GC = 3, GR = 3, EW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic       i_Edge_En;
  logic [8:0] i_Edge_Color, i_Cursor_Color;
  logic [1:0] i_Cursor_Col, i_Cursor_Row;
  logic       o_HSync, o_VSync, o_Frame_Start, o_Vblank;
  logic [2:0] o_Red, o_Green, o_Blue;
  logic [8:0] tile_mem [16];

  vga_grid_renderer_if #(.COL_W(2), .ROW_W(2), .COLOR_W(3)) tile_bus ();

  // Tile memory: colour indexed by {row, col}, ready before the capturing edge.
  assign tile_bus.i_Cell_Color = tile_mem[{tile_bus.o_Cell_Row, tile_bus.o_Cell_Col}];

  vga_grid_renderer #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .CELL_LOG2(CL), .GRID_COLS(GC), .GRID_ROWS(GR),
    .EDGE_W(EW), .COLOR_W(3)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Edge_En      (i_Edge_En),
    .i_Edge_Color   (i_Edge_Color),
    .i_Cursor_Col   (i_Cursor_Col),
    .i_Cursor_Row   (i_Cursor_Row),
    .i_Cursor_Color (i_Cursor_Color),
    .tile           (tile_bus.master),
    .o_HSync        (o_HSync),
    .o_VSync        (o_VSync),
    .o_Red          (o_Red),
    .o_Green        (o_Green),
    .o_Blue         (o_Blue),
    .o_Frame_Start  (o_Frame_Start),
    .o_Vblank       (o_Vblank)
  );

  // ---------------- scoreboard ----------------
  // pixel entry: {frame_start, vblank, hsync, vsync, rgb[8:0]}
  logic [12:0] exp_q[$];
  logic [3:0]  addr_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int k = 0;             // rising edges since reset release
  int settle_until = 0;  // first edge whose colour reflects the current config
  int next_cfg = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  // Reference model: what the pins should show for linear pixel index idx.
  function automatic logic [12:0] model_pixel(input int idx);
    int h, v, hc, vc, ho, vo;
    bit on_edge, fs, vb, hs, vs;
    logic [8:0] rgb;
    h  = idx % HT;
    v  = idx / HT;
    hc = h / CELL;
    vc = v / CELL;
    ho = h % CELL;
    vo = v % CELL;
    rgb = '0;
    if (h < HD && v < VD && h < GC * CELL && v < GR * CELL) begin
      on_edge = (ho < EW) || (ho >= CELL - EW) || (vo < EW) || (vo >= CELL - EW);
      if (on_edge && i_Edge_En)
        rgb = (int'(i_Cursor_Col) == hc && int'(i_Cursor_Row) == vc) ? i_Cursor_Color : i_Edge_Color;
      else
        rgb = tile_mem[vc * 4 + hc];
    end
    hs = !(h >= HD + HF && h < HD + HF + HS);  // active-low
    vs = !(v >= VD + VF && v < VD + VF + VS);
    vb = (v >= VD);
    fs = (idx == 0);
    return {fs, vb, hs, vs, rgb};
  endfunction

  function automatic logic [3:0] model_addr(input int idx);
    int hc, vc;
    hc = (idx % HT) / CELL;
    vc = (idx / HT) / CELL;
    if (hc > GC - 1) hc = GC - 1;
    if (vc > GR - 1) vc = GR - 1;
    return {2'(hc), 2'(vc)};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_config();
    i_Edge_En      = ($urandom_range(0, 3) != 0);
    i_Edge_Color   = 9'($urandom);
    i_Cursor_Color = 9'($urandom);
    i_Cursor_Col   = 2'($urandom_range(0, 3));
    i_Cursor_Row   = 2'($urandom_range(0, 3));
    for (int i = 0; i < 16; i++) tile_mem[i] = 9'($urandom);
  endtask

  task automatic push_expect(input int idx);
    exp_q.push_back(model_pixel(idx));
    addr_q.push_back(model_addr(idx));
  endtask

  task automatic restart_scoreboard();
    exp_q.delete();
    addr_q.delete();
    k = 0;
    settle_until = 0;
    next_cfg = $urandom_range(150, 400);
    push_expect(0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"},   {o_Red, o_Green, o_Blue}, 32'd0);
    check({tag, "_hsync"}, o_HSync, 32'd1);
    check({tag, "_vsync"}, o_VSync, 32'd1);
    check({tag, "_fs"},    o_Frame_Start, 32'd0);
    check({tag, "_vblank"}, o_Vblank, 32'd0);
    check({tag, "_addr"},  {tile_bus.o_Cell_Col, tile_bus.o_Cell_Row}, 32'd0);
  endtask

  task automatic step_and_check();
    logic [12:0] e;
    logic [3:0]  a;
    rgb_t        got;
    @(posedge clk);
    k++;
    @(negedge clk);
    if (k >= 1) begin
      a = addr_q.pop_front();
      check("cell_addr", {tile_bus.o_Cell_Col, tile_bus.o_Cell_Row}, a);
    end
    if (k >= 2) begin
      e = exp_q.pop_front();
      got = '{r: o_Red, g: o_Green, b: o_Blue};
      if (k >= settle_until) check("rgb", got, e[8:0]);
      check("vsync", o_VSync, e[9]);
      check("hsync", o_HSync, e[10]);
      check("vblank", o_Vblank, e[11]);
      check("frame_start", o_Frame_Start, e[12]);
    end
    push_expect(k % FRAME);
    if (k >= next_cfg) begin
      drive_config();
      settle_until = k + 3;
      next_cfg = k + $urandom_range(150, 400);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_config();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    restart_scoreboard();

    // Two full frames and part way into line 10 of the third.
    repeat (2 * FRAME + 10 * HT + $urandom_range(0, HT - 1)) step_and_check();

    // Mid-line reset: outputs must drop immediately, then a fresh frame.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    restart_scoreboard();

    repeat (2 * FRAME + 100) step_and_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
